// File: rtl/ad9516_cfg_seq.sv
// AD9516 power-up sequencer: writes each table entry via the SPI engine, optionally reads it back, then polls PLL lock.
// Per-entry latency follows the SPI engine; a transfer is only launched while spi_busy_i is low.
module ad9516_cfg_seq #(
  parameter int          TBL_DEPTH  = 64,
  parameter int          TBL_AW     = 6,
  parameter int          VERIFY     = 1,
  parameter int          MAX_RETRY  = 2,
  parameter logic [12:0] LOCK_ADDR  = 13'h01F,
  parameter int          LOCK_POLLS = 1000,
  parameter int          POLL_GAP   = 10000
) (
  input  logic              sys_clk_i,
  input  logic              rst_n_i,
  input  logic              cfg_start_i,
  output logic [TBL_AW-1:0] tbl_addr_o,
  input  logic [21:0]       tbl_data_i,
  output logic              spi_start_o,
  output logic [15:0]       spi_ctrl_o,
  output logic [7:0]        spi_wdata_o,
  input  logic [7:0]        spi_rdata_i,
  input  logic              spi_busy_i,
  output logic              cfg_busy_o,
  output logic              cfg_done_o,
  output logic              cfg_err_o,
  output logic [1:0]        err_code_o,
  output logic [12:0]       err_addr_o
);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int PW = (LOCK_POLLS < 1) ? 1 : $clog2(LOCK_POLLS + 1);
  localparam int GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
  localparam logic [TBL_AW-1:0] LAST_IDX  = TBL_AW'(TBL_DEPTH - 1);
  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [PW-1:0]     POLL_MAX  = PW'(LOCK_POLLS);
  localparam logic [GW-1:0]     GAP_LAST  = GW'((POLL_GAP < 1) ? 0 : POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR_ISS, S_WR_WAIT, S_RD_ISS, S_RD_WAIT, S_CHECK,
    S_NEXT, S_LK_ISS, S_LK_WAIT, S_LK_GAP, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [21:0]       ent_q, ent_d;
  logic              fph_q, fph_d;
  logic [1:0]        wph_q, wph_d;
  logic [7:0]        rd_q, rd_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [1:0]        code_q, code_d;
  logic [12:0]       eaddr_q, eaddr_d;
  logic              xfer_end;
  logic              rd_op, lk_op;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ent_q   <= '0;
      fph_q   <= 1'b0;
      wph_q   <= 2'd0;
      rd_q    <= '0;
      retry_q <= '0;
      poll_q  <= '0;
      gap_q   <= '0;
      code_q  <= 2'd0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ent_q   <= ent_d;
      fph_q   <= fph_d;
      wph_q   <= wph_d;
      rd_q    <= rd_d;
      retry_q <= retry_d;
      poll_q  <= poll_d;
      gap_q   <= gap_d;
      code_q  <= code_d;
      eaddr_q <= eaddr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ent_d       = ent_q;
    fph_d       = fph_q;
    wph_d       = wph_q;
    rd_d        = rd_q;
    retry_d     = retry_q;
    poll_d      = poll_q;
    gap_d       = gap_q;
    code_d      = code_q;
    eaddr_d     = eaddr_q;
    spi_start_o = 1'b0;
    xfer_end    = 1'b0;
    // Transfer tracking: busy rise, busy fall, then one cycle for read data to settle.
    if (state_q inside {S_WR_WAIT, S_RD_WAIT, S_LK_WAIT}) begin
      case (wph_q)
        2'd0:    if (spi_busy_i) wph_d = 2'd1;
        2'd1:    if (!spi_busy_i) wph_d = 2'd2;
        default: begin
          wph_d    = 2'd0;
          xfer_end = 1'b1;
        end
      endcase
    end
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (cfg_start_i) begin
        idx_d   = '0;
        fph_d   = 1'b0;
        code_d  = 2'd0;
        eaddr_d = '0;
        state_d = S_FETCH;
      end
      S_FETCH: if (!fph_q) fph_d = 1'b1;
        else begin
          fph_d   = 1'b0;
          ent_d   = tbl_data_i;
          retry_d = '0;
          state_d = S_WR_ISS;
        end
      S_WR_ISS, S_RD_ISS, S_LK_ISS: if (!spi_busy_i) begin
        spi_start_o = 1'b1;
        wph_d       = 2'd0;
        state_d     = (state_q == S_WR_ISS) ? S_WR_WAIT :
                      (state_q == S_RD_ISS) ? S_RD_WAIT : S_LK_WAIT;
      end
      S_WR_WAIT: if (xfer_end) state_d = (VERIFY != 0 && !ent_q[21]) ? S_RD_ISS : S_NEXT;
      S_RD_WAIT: if (xfer_end) begin
        rd_d    = spi_rdata_i;
        state_d = S_CHECK;
      end
      S_CHECK: if (rd_q == ent_q[7:0]) state_d = S_NEXT;
        else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + RW'(1);
          state_d = S_WR_ISS;
        end else begin
          code_d  = 2'd1;
          eaddr_d = ent_q[20:8];
          state_d = S_ERR;
        end
      S_NEXT: if (idx_q == LAST_IDX) begin
          poll_d  = '0;
          state_d = S_LK_ISS;
        end else begin
          idx_d   = idx_q + TBL_AW'(1);
          state_d = S_FETCH;
        end
      S_LK_WAIT: if (xfer_end) begin
        poll_d = poll_q + PW'(1);
        if (spi_rdata_i[0]) state_d = S_DONE;
        else if (poll_q + PW'(1) == POLL_MAX) begin
          code_d  = 2'd2;
          eaddr_d = LOCK_ADDR;
          state_d = S_ERR;
        end else begin
          gap_d   = '0;
          state_d = S_LK_GAP;
        end
      end
      S_LK_GAP: if (gap_q == GAP_LAST) state_d = S_LK_ISS;
        else gap_d = gap_q + GW'(1);
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction is derived from state so it stays constant for the whole transfer.
  assign rd_op       = state_q inside {S_RD_ISS, S_RD_WAIT};
  assign lk_op       = state_q inside {S_LK_ISS, S_LK_WAIT};
  assign spi_ctrl_o  = {rd_op | lk_op, 2'b00, lk_op ? LOCK_ADDR : ent_q[20:8]};
  assign spi_wdata_o = ent_q[7:0];
  assign tbl_addr_o  = idx_q;
  assign cfg_busy_o  = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign cfg_done_o  = (state_q == S_DONE);
  assign cfg_err_o   = (state_q == S_ERR);
  assign err_code_o  = code_q;
  assign err_addr_o  = eaddr_q;
endmodule

// File: tb/tb_ad9516_cfg_seq.sv
// Bench for ad9516_cfg_seq: ROM and SPI slave models; expected transfers and status are queued and
// checked by an independent monitor.
module tb_ad9516_cfg_seq;
  localparam int          POLL_GAP  = 20;
  localparam logic [12:0] LOCK_ADDR = 13'h01F;
  localparam logic [44:0] ALL_M  = '1;
  localparam logic [44:0] STAT_M = {1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 1'b1, 2'b11, 13'h1FFF, 2'b00};
  localparam logic [44:0] STTA_M = {1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 1'b1, 2'b11, 13'h1FFF, 2'b11};

  logic sys_clk = 1'b0, rst_n = 1'b0, cfg_start = 1'b0;
  logic [1:0]  tbl_addr;
  logic [21:0] tbl_data;
  logic        spi_start, spi_busy;
  logic [15:0] spi_ctrl;
  logic [7:0]  spi_wdata, spi_rdata;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [1:0]  err_code;
  logic [12:0] err_addr;
  logic [44:0] dut_v;

  ad9516_cfg_seq #(.TBL_DEPTH(3), .TBL_AW(2), .VERIFY(1), .MAX_RETRY(2), .LOCK_ADDR(LOCK_ADDR),
                   .LOCK_POLLS(4), .POLL_GAP(POLL_GAP)) dut (
    .sys_clk_i(sys_clk), .rst_n_i(rst_n), .cfg_start_i(cfg_start),
    .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
    .spi_start_o(spi_start), .spi_ctrl_o(spi_ctrl), .spi_wdata_o(spi_wdata),
    .spi_rdata_i(spi_rdata), .spi_busy_i(spi_busy),
    .cfg_busy_o(cfg_busy), .cfg_done_o(cfg_done), .cfg_err_o(cfg_err),
    .err_code_o(err_code), .err_addr_o(err_addr));

  always #5 sys_clk = ~sys_clk;
  assign dut_v = {spi_start, spi_ctrl, spi_wdata, cfg_busy, cfg_done, cfg_err, err_code, err_addr, tbl_addr};

  logic [21:0] rom [0:3];
  always @(posedge sys_clk) tbl_data <= rom[tbl_addr];

  // SPI slave: busy 3 cycles, echoes writes unless the 0x010 register is stuck at zero.
  logic [7:0]  mem [0:8191];
  logic        stuck = 1'b0;
  logic [7:0]  lock_val = 8'h01;
  int          sl_cnt;
  logic [15:0] sl_ctrl;
  logic [7:0]  sl_wd;
  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_busy <= 1'b0; sl_cnt <= 0; spi_rdata <= 8'h00; sl_ctrl <= 16'h0; sl_wd <= 8'h0;
    end else if (spi_start) begin
      spi_busy <= 1'b1; sl_cnt <= 3; sl_ctrl <= spi_ctrl; sl_wd <= spi_wdata;
    end else if (spi_busy) begin
      sl_cnt <= sl_cnt - 1;
      if (sl_cnt == 1) begin
        spi_busy <= 1'b0;
        if (!sl_ctrl[15]) begin
          if (!(stuck && sl_ctrl[12:0] == 13'h010)) mem[sl_ctrl[12:0]] <= sl_wd;
        end else if (sl_ctrl[12:0] == LOCK_ADDR) spi_rdata <= lock_val;
        else if (stuck && sl_ctrl[12:0] == 13'h010) spi_rdata <= 8'h00;
        else spi_rdata <= mem[sl_ctrl[12:0]];
      end
    end
  end

  typedef struct { logic [15:0] ctrl; logic [7:0] wd; bit wr; } tx_t;
  typedef struct { logic done; logic err; logic [1:0] code; logic [12:0] addr; } st_t;
  typedef struct { logic [44:0] exp; logic [44:0] mask; } pt_t;
  tx_t   exp_tx[$];
  st_t   exp_st[$];
  pt_t   pt_q[$];
  string pt_nm[$];

  int checks = 0, errors = 0;
  int cyc = 0, last_lk = -1, tx_cnt = 0, to_cnt = 0, to_seen = 0;
  bit end_req = 1'b0, end_done = 1'b0;
  logic  st_prev = 1'b0;
  tx_t   m_e;
  st_t   m_s;
  pt_t   m_p;
  string m_nm;

  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(posedge sys_clk) if (spi_start) tx_cnt <= tx_cnt + 1;

  always @(negedge sys_clk) begin
    if (spi_start) begin
      checks++;
      if (spi_busy) begin errors++; $display("FAIL start_while_busy: busy=%0b required 0", spi_busy); end
      if (exp_tx.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_tx: ctrl=%04h required no transfer", spi_ctrl);
      end else begin
        m_e = exp_tx.pop_front();
        checks++;
        if (spi_ctrl !== m_e.ctrl) begin errors++; $display("FAIL spi_ctrl: got %04h required %04h", spi_ctrl, m_e.ctrl); end
        if (m_e.wr) begin
          checks++;
          if (spi_wdata !== m_e.wd) begin errors++; $display("FAIL spi_wdata: got %02h required %02h", spi_wdata, m_e.wd); end
        end
      end
      if (spi_ctrl == {3'b100, LOCK_ADDR}) begin
        if (last_lk >= 0) begin
          checks++;
          if (cyc - last_lk < POLL_GAP) begin errors++; $display("FAIL lock_gap: got %0d cycles required >= %0d", cyc - last_lk, POLL_GAP); end
        end
        last_lk = cyc;
      end else last_lk = -1;
    end
    if (spi_busy && !spi_start) begin
      checks++;
      if (spi_ctrl !== sl_ctrl) begin errors++; $display("FAIL ctrl_stable: got %04h required %04h", spi_ctrl, sl_ctrl); end
    end
    if ((cfg_done || cfg_err) && !st_prev) begin
      checks++;
      if (exp_st.size() == 0) begin
        errors++; $display("FAIL unexpected_status: done=%0b err=%0b required none", cfg_done, cfg_err);
      end else begin
        m_s = exp_st.pop_front();
        if ({cfg_done, cfg_err, err_code, err_addr} !== {m_s.done, m_s.err, m_s.code, m_s.addr}) begin
          errors++;
          $display("FAIL status: got done=%0b err=%0b code=%0d addr=%03h required done=%0b err=%0b code=%0d addr=%03h",
                   cfg_done, cfg_err, err_code, err_addr, m_s.done, m_s.err, m_s.code, m_s.addr);
        end
      end
    end
    st_prev = cfg_done || cfg_err;
    while (pt_q.size() > 0) begin
      m_p = pt_q.pop_front(); m_nm = pt_nm.pop_front();
      checks++;
      if ((dut_v & m_p.mask) !== (m_p.exp & m_p.mask)) begin
        errors++; $display("FAIL %s: got %012h required %012h", m_nm, dut_v & m_p.mask, m_p.exp & m_p.mask);
      end
    end
    if (to_cnt != to_seen) begin
      checks++; errors++; $display("FAIL timeout: got %0d expired waits required 0", to_cnt - to_seen);
      to_seen = to_cnt;
    end
    if (end_req && !end_done) begin
      end_done = 1'b1;
      checks++;
      if (exp_tx.size() != 0) begin errors++; $display("FAIL missing_tx: got %0d outstanding required 0", exp_tx.size()); end
      checks++;
      if (exp_st.size() != 0) begin errors++; $display("FAIL missing_status: got %0d outstanding required 0", exp_st.size()); end
    end
  end

  function automatic logic [44:0] ov(input logic b, input logic d, input logic e,
                                     input logic [1:0] code, input logic [12:0] a, input logic [1:0] ta);
    return {1'b0, 16'h0, 8'h0, b, d, e, code, a, ta};
  endfunction
  task automatic push_w(input logic [12:0] a, input logic [7:0] d);
    tx_t t; t.ctrl = {3'b000, a}; t.wd = d; t.wr = 1'b1; exp_tx.push_back(t);
  endtask
  task automatic push_r(input logic [12:0] a);
    tx_t t; t.ctrl = {3'b100, a}; t.wd = 8'h00; t.wr = 1'b0; exp_tx.push_back(t);
  endtask
  task automatic push_st(input logic d, input logic e, input logic [1:0] code, input logic [12:0] a);
    st_t s; s.done = d; s.err = e; s.code = code; s.addr = a; exp_st.push_back(s);
  endtask
  task automatic push_pt(input string nm, input logic [44:0] exp, input logic [44:0] mask);
    pt_t p; p.exp = exp; p.mask = mask; pt_q.push_back(p); pt_nm.push_back(nm);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask
  task automatic start_seq(input string nm);
    tick(1); cfg_start = 1'b1;
    tick(1); cfg_start = 1'b0;
    push_pt(nm, ov(1'b1, 1'b0, 1'b0, 2'd0, 13'h0, 2'd0), STAT_M);
  endtask
  task automatic wait_end(input int budget);
    int i = 0;
    while (i < budget && !(cfg_done || cfg_err)) begin tick(1); i++; end
    if (!(cfg_done || cfg_err)) to_cnt++;
    tick(3);
  endtask
  task automatic wait_tx(input int n, input int budget);
    int i = 0;
    while (i < budget && tx_cnt < n) begin tick(1); i++; end
    if (tx_cnt < n) to_cnt++;
  endtask
  task automatic load_skip_tbl();
    rom[0] = {1'b1, 13'h100, 8'h11}; rom[1] = {1'b1, 13'h101, 8'h22};
    rom[2] = {1'b1, 13'h102, 8'h33}; rom[3] = 22'h0;
  endtask
  task automatic load_vfy_tbl();
    rom[0] = {1'b0, 13'h010, 8'h7C}; rom[1] = {1'b1, 13'h232, 8'h01};
    rom[2] = {1'b0, 13'h011, 8'hA5}; rom[3] = 22'h0;
  endtask
  task automatic push_vfy_seq();
    push_w(13'h010, 8'h7C); push_r(13'h010);
    push_w(13'h232, 8'h01);
    push_w(13'h011, 8'hA5); push_r(13'h011);
    push_r(LOCK_ADDR);
  endtask

  int base;
  initial begin
    load_skip_tbl();
    tick(2);
    push_pt("reset_outputs", 45'h0, ALL_M);
    tick(1); rst_n = 1'b1; tick(2);

    // Write-only table (every entry skip-verify), PLL locks on first read.
    push_w(13'h100, 8'h11); push_w(13'h101, 8'h22); push_w(13'h102, 8'h33); push_r(LOCK_ADDR);
    push_st(1'b1, 1'b0, 2'd0, 13'h0);
    start_seq("t1_busy");
    wait_end(2000);

    // Verified entries read back; the skip-verify entry 0x232 gets no readback.
    load_vfy_tbl();
    push_vfy_seq();
    push_st(1'b1, 1'b0, 2'd0, 13'h0);
    start_seq("t2_restart_from_done");
    wait_end(2000);

    // Register 0x010 never takes the value: initial write plus two retries, then verify error.
    stuck = 1'b1;
    for (int i = 0; i < 3; i++) begin push_w(13'h010, 8'h7C); push_r(13'h010); end
    push_st(1'b0, 1'b1, 2'd1, 13'h010);
    start_seq("t3_busy");
    wait_end(2000);

    // PLL never locks: four lock reads then timeout error.
    stuck = 1'b0; lock_val = 8'h00;
    load_skip_tbl();
    push_w(13'h100, 8'h11); push_w(13'h101, 8'h22); push_w(13'h102, 8'h33);
    for (int i = 0; i < 4; i++) push_r(LOCK_ADDR);
    push_st(1'b0, 1'b1, 2'd2, LOCK_ADDR);
    start_seq("t5_restart_clears_err");
    wait_end(3000);

    // Reset during the entry-1 write, then a clean restart with an ignored mid-transfer start.
    lock_val = 8'h01;
    load_vfy_tbl();
    base = tx_cnt;
    push_w(13'h010, 8'h7C); push_r(13'h010); push_w(13'h232, 8'h01);
    start_seq("t6_busy");
    wait_tx(base + 3, 500);
    tick(1);
    rst_n = 1'b0;
    push_pt("t6_reset_abort", 45'h0, ALL_M);
    tick(2); rst_n = 1'b1; tick(2);
    base = tx_cnt;
    push_vfy_seq();
    push_st(1'b1, 1'b0, 2'd0, 13'h0);
    start_seq("t6_restart");
    wait_tx(base + 1, 500);
    cfg_start = 1'b1; tick(1); cfg_start = 1'b0;
    push_pt("t6_start_ignored", ov(1'b1, 1'b0, 1'b0, 2'd0, 13'h0, 2'd0), STTA_M);
    wait_end(2000);

    end_req = 1'b1;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
